hammu_hamnhan_axi_master: RTL and testbench

AXI4-Lite initiator that drives the hammu_hamnhan exponent/multiplier slave.

---
 rtl/hammu_hamnhan_axi_master.sv | 179 +++++++++++++++++
 tb/tb_hammu_hamnhan_axi_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hammu_hamnhan_axi_master.sv
// AXI4-Lite initiator for the hammu_hamnhan multiply/power slave: writes A, B and CTRL,
// polls STATUS until done (or timeout), reads RESULT and returns it on the response port.
module hammu_hamnhan_axi_master #(
  parameter logic [31:0] C_BASEADDR     = 32'h74400000,
  parameter int          C_POLL_LIMIT   = 16,
  parameter int          C_M_AXI_DWIDTH = 32
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_op,
  input  logic [C_M_AXI_DWIDTH-1:0] cmd_a,
  input  logic [C_M_AXI_DWIDTH-1:0] cmd_b,
  output logic                      rsp_valid,
  output logic [C_M_AXI_DWIDTH-1:0] rsp_data,
  output logic                      rsp_err,
  output logic [31:0]               M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [C_M_AXI_DWIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]                M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [31:0]               M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [C_M_AXI_DWIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  localparam logic [31:0] OFF_A      = 32'h00;
  localparam logic [31:0] OFF_B      = 32'h04;
  localparam logic [31:0] OFF_CTRL   = 32'h08;
  localparam logic [31:0] OFF_STATUS = 32'h0C;
  localparam logic [31:0] OFF_RESULT = 32'h10;
  localparam logic [15:0] POLL_LAST  = 16'(C_POLL_LIMIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_CTRL,
    ST_RD_STAT,
    ST_RD_RES,
    ST_RESP
  } state_t;

  state_t                    state, state_next;
  logic                      aw_done, w_done, ar_done;
  logic [15:0]               poll_cnt;
  logic                      op_q;
  logic [C_M_AXI_DWIDTH-1:0] a_q, b_q;
  logic                      is_write, is_read;
  logic                      b_fire, r_fire, b_err, r_err;
  logic                      load_rsp, rsp_err_next;
  logic [C_M_AXI_DWIDTH-1:0] rsp_data_next;

  assign M_AXI_WSTRB = 4'b1111;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) state <= ST_IDLE;
    else              state <= state_next;
  end

  // VALID/READY come straight from registered state so an async reset drops them at once,
  // and address/data are a function of state alone so they cannot move during a stall.
  always_comb begin
    state_next    = state;
    is_write      = (state == ST_WR_A) || (state == ST_WR_B) || (state == ST_WR_CTRL);
    is_read       = (state == ST_RD_STAT) || (state == ST_RD_RES);
    cmd_ready     = (state == ST_IDLE);
    M_AXI_AWVALID = is_write && !aw_done;
    M_AXI_WVALID  = is_write && !w_done;
    M_AXI_BREADY  = is_write;
    M_AXI_ARVALID = is_read && !ar_done;
    M_AXI_RREADY  = is_read;
    M_AXI_AWADDR  = '0;
    M_AXI_WDATA   = '0;
    M_AXI_ARADDR  = '0;
    b_fire        = is_write && M_AXI_BVALID;
    r_fire        = is_read && M_AXI_RVALID;
    b_err         = b_fire && (M_AXI_BRESP != 2'b00);
    r_err         = r_fire && (M_AXI_RRESP != 2'b00);
    load_rsp      = 1'b0;
    rsp_err_next  = 1'b0;
    rsp_data_next = '0;
    case (state)
      ST_IDLE: if (cmd_valid) state_next = ST_WR_A;
      ST_WR_A: begin
        M_AXI_AWADDR = C_BASEADDR + OFF_A;
        M_AXI_WDATA  = a_q;
        if (b_fire) state_next = ST_WR_B;
      end
      ST_WR_B: begin
        M_AXI_AWADDR = C_BASEADDR + OFF_B;
        M_AXI_WDATA  = b_q;
        if (b_fire) state_next = ST_WR_CTRL;
      end
      ST_WR_CTRL: begin
        M_AXI_AWADDR = C_BASEADDR + OFF_CTRL;
        M_AXI_WDATA  = {{(C_M_AXI_DWIDTH-2){1'b0}}, op_q, 1'b1};
        if (b_fire) state_next = ST_RD_STAT;
      end
      ST_RD_STAT: begin
        M_AXI_ARADDR = C_BASEADDR + OFF_STATUS;
        if (r_fire) begin
          if (M_AXI_RDATA[0]) begin
            state_next = ST_RD_RES;
          end else if (poll_cnt == POLL_LAST) begin
            state_next   = ST_RESP;
            load_rsp     = 1'b1;
            rsp_err_next = 1'b1;
          end
        end
      end
      ST_RD_RES: begin
        M_AXI_ARADDR = C_BASEADDR + OFF_RESULT;
        if (r_fire) begin
          state_next    = ST_RESP;
          load_rsp      = 1'b1;
          rsp_data_next = M_AXI_RDATA;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (b_err || r_err) begin
      state_next    = ST_RESP;
      load_rsp      = 1'b1;
      rsp_err_next  = 1'b1;
      rsp_data_next = '0;
    end
  end

  // Per-channel handshake flags clear when the transfer's response completes, so a
  // repeated STATUS poll simply re-issues the address phase.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      ar_done   <= 1'b0;
      poll_cnt  <= '0;
      op_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        op_q <= cmd_op;
        a_q  <= cmd_a;
        b_q  <= cmd_b;
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
      if (M_AXI_WVALID && M_AXI_WREADY)   w_done  <= 1'b1;
      if (b_fire) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) ar_done <= 1'b1;
      if (r_fire) ar_done <= 1'b0;
      if (state == ST_WR_CTRL && state_next == ST_RD_STAT) poll_cnt <= '0;
      else if (state == ST_RD_STAT && r_fire)              poll_cnt <= poll_cnt + 16'd1;
      rsp_valid <= load_rsp;
      if (load_rsp) begin
        rsp_data <= rsp_data_next;
        rsp_err  <= rsp_err_next;
      end
    end
  end

endmodule

// File: tb/tb_hammu_hamnhan_axi_master.sv
// Directed bench for hammu_hamnhan_axi_master with a behavioural AXI4-Lite slave that
// models the multiply/power register map, configurable ready/response delays and errors.
`timescale 1ns/1ps
module tb_hammu_hamnhan_axi_master;

  localparam logic [31:0] BASE = 32'h74400000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  hammu_hamnhan_axi_master #(
    .C_BASEADDR     (BASE),
    .C_POLL_LIMIT   (4),
    .C_M_AXI_DWIDTH (32)
  ) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESET  (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
  );

  int checks = 0;
  int errors = 0;

  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0;
  int bresp_err_idx = -1, done_after = 1;
  int wr_count = 0, stat_reads = 0, res_reads = 0, stalls = 0;
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];
  logic [31:0] reg_a = 0, reg_b = 0;
  logic        reg_op = 0;

  bit aw_got, w_got, ar_got, aw_fire, w_fire, b_fire, ar_fire, r_fire;
  bit aw_stall, w_stall, ar_stall;
  int aw_wait, w_wait, b_wait, ar_wait;
  logic [31:0] aw_cap, w_cap, ar_cap;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] slave_result();
    logic [31:0] r;
    if (reg_op) begin
      r = 32'd1;
      for (logic [31:0] i = 0; i < reg_b; i++) r = r * reg_a;
    end else begin
      r = reg_a * reg_b;
    end
    return r;
  endfunction

  // Slave: drives at negedges; handshakes decided here complete at the following posedge.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        aw_stall = 0; w_stall = 0; ar_stall = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0;
      end else begin
        if (aw_stall) begin
          checkOutput("awvalid_hold", 32'(awvalid), 32'd1);
          checkOutput("awaddr_hold", awaddr, aw_cap);
        end
        if (w_stall) begin
          checkOutput("wvalid_hold", 32'(wvalid), 32'd1);
          checkOutput("wdata_hold", wdata, w_cap);
        end
        if (ar_stall) begin
          checkOutput("arvalid_hold", 32'(arvalid), 32'd1);
          checkOutput("araddr_hold", araddr, ar_cap);
        end
        if (aw_fire) aw_got = 1;
        if (w_fire) w_got = 1;
        if (b_fire) begin
          if (wr_count < 8) begin
            wr_addr[wr_count] = aw_cap;
            wr_data[wr_count] = w_cap;
          end
          wr_count++;
          if (aw_cap == BASE + 32'h00) reg_a = w_cap;
          if (aw_cap == BASE + 32'h04) reg_b = w_cap;
          if (aw_cap == BASE + 32'h08) reg_op = w_cap[1];
          aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        end
        if (ar_fire) ar_got = 1;
        if (r_fire) begin
          if (ar_cap == BASE + 32'h0C) stat_reads++;
          if (ar_cap == BASE + 32'h10) res_reads++;
          ar_got = 0; ar_wait = 0;
        end
        if (awvalid && !aw_got) begin awready = (aw_wait >= aw_delay); aw_wait++; end
        else awready = 0;
        if (wvalid && !w_got) begin wready = (w_wait >= w_delay); w_wait++; end
        else wready = 0;
        if (aw_got && w_got) begin
          bvalid = (b_wait >= b_delay);
          b_wait++;
          bresp = (wr_count == bresp_err_idx) ? 2'b10 : 2'b00;
        end else begin
          bvalid = 0; bresp = 0;
        end
        if (arvalid && !ar_got) begin arready = (ar_wait >= ar_delay); ar_wait++; end
        else arready = 0;
        if (ar_got) begin
          rvalid = 1;
          if (ar_cap == BASE + 32'h0C) rdata = {31'b0, (stat_reads + 1 >= done_after)};
          else if (ar_cap == BASE + 32'h10) rdata = slave_result();
          else rdata = 0;
        end else begin
          rvalid = 0; rdata = 0;
        end
        aw_fire = awvalid && awready;
        w_fire  = wvalid && wready;
        b_fire  = bvalid && bready;
        ar_fire = arvalid && arready;
        r_fire  = rvalid && rready;
        aw_stall = awvalid && !awready;
        w_stall  = wvalid && !wready;
        ar_stall = arvalid && !arready;
        if (awvalid) aw_cap = awaddr;
        if (wvalid) w_cap = wdata;
        if (arvalid) ar_cap = araddr;
        if (aw_stall || w_stall || ar_stall) stalls++;
      end
    end
  end

  // Issues one command and returns the number of cycles from accept to rsp_valid.
  task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [31:0] b,
                               output int latency);
    bit accepted = 0;
    latency = -1;
    @(negedge clk);
    wr_count = 0; stat_reads = 0; res_reads = 0; stalls = 0;
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin accepted = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 0;
    if (!accepted) begin
      checkOutput("cmd_accept", 32'd0, 32'd1);
      return;
    end
    for (int k = 1; k <= 300; k++) begin
      if (rsp_valid) begin latency = k; break; end
      @(negedge clk);
    end
    if (latency < 0) checkOutput("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    bit found;
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_valid_ready", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
    checkOutput("reset_rsp", {rsp_data[30:0], rsp_err}, 32'd0);
    checkOutput("reset_awaddr", awaddr, 32'd0);
    #2 rst = 0;

    $display("[TB] multiply 7*6");
    applyStimulus(1'b0, 32'd7, 32'd6, lat);
    checkOutput("mul_data", rsp_data, 32'd42);
    checkOutput("mul_err", 32'(rsp_err), 32'd0);
    checkOutput("mul_latency", 32'(lat), 32'd11);
    checkOutput("mul_wr_count", 32'(wr_count), 32'd3);
    checkOutput("mul_wr0_addr", wr_addr[0], BASE);
    checkOutput("mul_wr0_data", wr_data[0], 32'd7);
    checkOutput("mul_wr1_addr", wr_addr[1], BASE + 32'h04);
    checkOutput("mul_wr1_data", wr_data[1], 32'd6);
    checkOutput("mul_wr2_addr", wr_addr[2], BASE + 32'h08);
    checkOutput("mul_ctrl", wr_data[2], 32'h1);
    checkOutput("mul_wstrb", 32'(wstrb), 32'hF);
    checkOutput("mul_stat_reads", 32'(stat_reads), 32'd1);
    checkOutput("mul_res_reads", 32'(res_reads), 32'd1);
    @(negedge clk);
    checkOutput("mul_rsp_pulse", 32'(rsp_valid), 32'd0);
    checkOutput("mul_idle_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mul_rsp_hold", rsp_data, 32'd42);

    $display("[TB] power 2^10, done on third poll");
    done_after = 3;
    applyStimulus(1'b1, 32'd2, 32'd10, lat);
    checkOutput("pow_data", rsp_data, 32'd1024);
    checkOutput("pow_err", 32'(rsp_err), 32'd0);
    checkOutput("pow_ctrl", wr_data[2], 32'h3);
    checkOutput("pow_stat_reads", 32'(stat_reads), 32'd3);
    checkOutput("pow_latency", 32'(lat), 32'd15);

    $display("[TB] backpressure 13*11");
    done_after = 1; aw_delay = 3; w_delay = 0; b_delay = 4; ar_delay = 2;
    applyStimulus(1'b0, 32'd13, 32'd11, lat);
    checkOutput("bp_data", rsp_data, 32'd143);
    checkOutput("bp_err", 32'(rsp_err), 32'd0);
    checkOutput("bp_stall_seen", 32'(stalls > 0), 32'd1);
    checkOutput("bp_wr_count", 32'(wr_count), 32'd3);
    aw_delay = 0; b_delay = 0; ar_delay = 0;

    $display("[TB] write error on B");
    bresp_err_idx = 1;
    applyStimulus(1'b0, 32'd3, 32'd4, lat);
    checkOutput("err_flag", 32'(rsp_err), 32'd1);
    checkOutput("err_data", rsp_data, 32'd0);
    checkOutput("err_wr_count", 32'(wr_count), 32'd2);
    checkOutput("err_stat_reads", 32'(stat_reads), 32'd0);
    checkOutput("err_latency", 32'(lat), 32'd5);
    bresp_err_idx = -1;

    $display("[TB] poll timeout");
    done_after = 1000;
    applyStimulus(1'b1, 32'd3, 32'd3, lat);
    checkOutput("to_flag", 32'(rsp_err), 32'd1);
    checkOutput("to_data", rsp_data, 32'd0);
    checkOutput("to_stat_reads", 32'(stat_reads), 32'd4);
    checkOutput("to_res_reads", 32'(res_reads), 32'd0);
    checkOutput("to_latency", 32'(lat), 32'd15);
    done_after = 1;

    $display("[TB] reset during CTRL write");
    applyStimulus(1'b0, 32'd4, 32'd4, lat);
    checkOutput("pre_reset_data", rsp_data, 32'd16);
    aw_delay = 3;
    @(negedge clk);
    cmd_valid = 1; cmd_op = 1; cmd_a = 32'd9; cmd_b = 32'd2;
    @(negedge clk);
    cmd_valid = 0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (awvalid && awaddr == BASE + 32'h08) begin found = 1; break; end
      @(negedge clk);
    end
    checkOutput("ctrl_write_reached", 32'(found), 32'd1);
    #2 rst = 1;
    #1;
    checkOutput("midreset_valid_ready", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    checkOutput("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("midreset_rsp_data", rsp_data, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 0;
    aw_delay = 0;
    applyStimulus(1'b0, 32'd5, 32'd9, lat);
    checkOutput("post_reset_data", rsp_data, 32'd45);
    checkOutput("post_reset_err", 32'(rsp_err), 32'd0);
    checkOutput("post_reset_latency", 32'(lat), 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
